// File: rtl/fft_input_framer_if.sv
// ---------------------------------------------------------------------------
// fft_input_framer_if
//   Stream bundle between the sample source, the framer and the FFT core.
//   master : the environment side. It drives samples and fft_ready, and it
//            observes the frame stream.
//   slave  : the framer side.
// Signals
//   in_data/in_valid/in_ready    : natural-order sample stream into the framer
//   fft_ready                    : FFT can take a new frame
//   out_data/out_valid/out_last  : framed burst towards the FFT core
// ---------------------------------------------------------------------------
interface fft_input_framer_if #(
    parameter int W = 16
) ();
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         fft_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_last;

    modport master (
        output in_data, in_valid, fft_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, fft_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/fft_input_framer.sv
// ---------------------------------------------------------------------------
// fft_input_framer
//   Collects a natural-order sample stream into two ping-pong frame banks of
//   NSamples each. Every complete frame is replayed to a streaming FFT as one
//   gapless burst of NSamples valid cycles. The replay order is either
//   natural or bit-reversed (BitRevOut).
// Ports
//   clk        : clock
//   reset      : synchronous, active-high
//   bus        : fft_input_framer_if.slave (sample input, FFT output, fft_ready)
//   overflow   : sticky; a sample was offered while in_ready was low
//   frames_out : number of frames emitted, wraps at 2^16
// ---------------------------------------------------------------------------
module fft_input_framer #(
    parameter int NSamples  = 64,
    parameter int W         = 16,
    parameter int BitRevOut = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    fft_input_framer_if.slave    bus,
    output logic                 overflow,
    output logic [15:0]          frames_out
);
    localparam int NBits = $clog2(NSamples);

    typedef enum logic {
        RD_IDLE,
        RD_STREAM
    } rd_state_t;

    rd_state_t        rd_state, rd_state_nxt;
    logic [NBits-1:0] wr_idx;
    logic [NBits-1:0] rd_idx, rd_idx_nxt;
    logic [NBits-1:0] rd_addr;
    logic             wr_bank, wr_bank_nxt;
    logic             rd_bank;
    logic [1:0]       bank_full, bank_full_nxt;
    logic             wr_fire, wr_last;
    logic             rd_issue, rd_last;

    // Both banks in one array. The address is {bank, index}.
    logic [W-1:0] mem [0:2*NSamples-1];

    function automatic logic [NBits-1:0] bitrev(input logic [NBits-1:0] a);
        logic [NBits-1:0] r;
        for (int i = 0; i < NBits; i++) begin
            r[i] = a[NBits-1-i];
        end
        return r;
    endfunction

    // ---------------- write side ----------------
    assign wr_fire     = bus.in_valid && bus.in_ready;
    assign wr_last     = wr_fire && (wr_idx == NBits'(NSamples - 1));
    assign wr_bank_nxt = wr_bank ^ wr_last;

    // ---------------- read FSM: next state ----------------
    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        rd_state_nxt = rd_state;
        rd_idx_nxt   = rd_idx;
        rd_issue     = 1'b0;
        rd_last      = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (bank_full[rd_bank] && bus.fft_ready) begin
                    rd_state_nxt = RD_STREAM;
                    rd_idx_nxt   = '0;
                end
            end
            RD_STREAM: begin
                // fft_ready is deliberately ignored here: a started burst
                // always runs to completion without gaps.
                rd_issue   = 1'b1;
                rd_idx_nxt = rd_idx + NBits'(1);
                if (rd_idx == NBits'(NSamples - 1)) begin
                    rd_last      = 1'b1;
                    rd_state_nxt = RD_IDLE;
                end
            end
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    assign rd_addr = (BitRevOut != 0) ? bitrev(rd_idx) : rd_idx;

    // The writer can only fill the bank the reader is not draining, so the
    // set and clear below never target the same bit in the same cycle.
    always_comb begin
        bank_full_nxt = bank_full;
        if (rd_last) bank_full_nxt[rd_bank] = 1'b0;
        if (wr_last) bank_full_nxt[wr_bank] = 1'b1;
    end

    // ---------------- state registers ----------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state      <= RD_IDLE;
            rd_idx        <= '0;
            rd_bank       <= 1'b0;
            wr_bank       <= 1'b0;
            wr_idx        <= '0;
            bank_full     <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_data  <= '0;
            overflow      <= 1'b0;
            frames_out    <= '0;
        end else begin
            rd_state  <= rd_state_nxt;
            rd_idx    <= rd_idx_nxt;
            bank_full <= bank_full_nxt;
            wr_bank   <= wr_bank_nxt;
            if (wr_fire) wr_idx <= wr_idx + NBits'(1);   // wraps at NSamples

            // Registered from next-state values, so in_ready never depends
            // combinationally on in_valid. The reader freeing a bank in the
            // same cycle the writer fills one keeps in_ready high.
            bus.in_ready <= !bank_full_nxt[wr_bank_nxt];

            if (bus.in_valid && !bus.in_ready) overflow <= 1'b1;

            // Registered RAM read: data appears one cycle after the read is
            // issued. out_data is held between bursts.
            bus.out_valid <= rd_issue;
            bus.out_last  <= rd_last;
            if (rd_issue) bus.out_data <= mem[{rd_bank, rd_addr}];

            if (rd_last) begin
                rd_bank    <= ~rd_bank;
                frames_out <= frames_out + 16'd1;
            end
        end
    end

    // NOTE: the frame storage is deliberately not reset. Bank validity is
    // carried by bank_full, and a reset array could not map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[{wr_bank, wr_idx}] <= bus.in_data;
    end

endmodule

// File: tb/tb_fft_input_framer.sv
// ---------------------------------------------------------------------------
// tb_fft_input_framer
//   Directed bench for fft_input_framer with NSamples=8 and W=16. Two
//   instances share one stimulus: one emits in bit-reversed order and one
//   emits in natural order. Inputs are driven and outputs sampled on the
//   falling edge.
// ---------------------------------------------------------------------------
module tb_fft_input_framer;
    localparam int N = 8;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         fft_ready;

    logic         overflow_br, overflow_nat;
    logic [15:0]  frames_br, frames_nat;

    int n_cmp = 0;
    int n_err = 0;

    // Hand-derived 3-bit bit-reversal: output beat k reads sample br_idx[k].
    int br_idx [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

    always #5 clk = ~clk;

    fft_input_framer_if #(.W(W)) bus_br  ();
    fft_input_framer_if #(.W(W)) bus_nat ();

    assign bus_br.in_data    = in_data;
    assign bus_br.in_valid   = in_valid;
    assign bus_br.fft_ready  = fft_ready;
    assign bus_nat.in_data   = in_data;
    assign bus_nat.in_valid  = in_valid;
    assign bus_nat.fft_ready = fft_ready;

    fft_input_framer #(.NSamples(N), .W(W), .BitRevOut(1)) dut_br (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_br),
        .overflow   (overflow_br),
        .frames_out (frames_br)
    );

    fft_input_framer #(.NSamples(N), .W(W), .BitRevOut(0)) dut_nat (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_nat),
        .overflow   (overflow_nat),
        .frames_out (frames_nat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_state(input string tag, input logic [15:0] frames);
        check({tag, "/br_in_ready"},   bus_br.in_ready,   1);
        check({tag, "/nat_in_ready"},  bus_nat.in_ready,  1);
        check({tag, "/br_out_valid"},  bus_br.out_valid,  0);
        check({tag, "/nat_out_valid"}, bus_nat.out_valid, 0);
        check({tag, "/br_out_last"},   bus_br.out_last,   0);
        check({tag, "/nat_out_last"},  bus_nat.out_last,  0);
        check({tag, "/br_overflow"},   overflow_br,       0);
        check({tag, "/nat_overflow"},  overflow_nat,      0);
        check({tag, "/br_frames"},     frames_br,         frames);
        check({tag, "/nat_frames"},    frames_nat,        frames);
    endtask

    // Offers base..base+N-1. With gaps set, random idle cycles are inserted.
    // Returns on the falling edge one cycle after the last sample was driven.
    task automatic feed(input logic [W-1:0] base, input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = base + W'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Waits up to max_wait cycles for a burst, then checks all N beats on both
    // instances. drop_at lowers fft_ready at that beat. abort_at asserts reset
    // at that beat and returns. Otherwise the task returns on the gap cycle
    // after the burst.
    task automatic expect_frame(input logic [W-1:0] base, input int max_wait,
                                input int drop_at, input int abort_at, input string tag);
        int waited = 0;
        while (!bus_nat.out_valid && waited < max_wait) begin
            @(negedge clk);
            waited++;
        end
        if (!bus_nat.out_valid) begin
            check({tag, "/start_timeout"}, 0, 1);
            return;
        end
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s/b%0d_nat_valid", tag, k), bus_nat.out_valid, 1);
            check($sformatf("%s/b%0d_br_valid", tag, k),  bus_br.out_valid,  1);
            check($sformatf("%s/b%0d_nat_data", tag, k),  bus_nat.out_data,  base + W'(k));
            check($sformatf("%s/b%0d_br_data", tag, k),   bus_br.out_data,   base + W'(br_idx[k]));
            check($sformatf("%s/b%0d_nat_last", tag, k),  bus_nat.out_last,  (k == N-1));
            check($sformatf("%s/b%0d_br_last", tag, k),   bus_br.out_last,   (k == N-1));
            if (k == drop_at) fft_ready = 1'b0;
            if (k == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        check({tag, "/gap_nat_valid"}, bus_nat.out_valid, 0);
        check({tag, "/gap_br_valid"},  bus_br.out_valid,  0);
        check({tag, "/gap_nat_last"},  bus_nat.out_last,  0);
        check({tag, "/hold_nat_data"}, bus_nat.out_data,  base + W'(N-1));
        check({tag, "/hold_br_data"},  bus_br.out_data,   base + W'(N-1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        fft_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_idle_state("reset", 16'd0);
        check("reset/nat_data", bus_nat.out_data, 0);
        check("reset/br_data",  bus_br.out_data,  0);
        reset = 1'b0;
        @(negedge clk);

        // T1: natural fill 0..7, fft_ready high
        fft_ready = 1'b1;
        feed(16'h0000, 1'b0);
        expect_frame(16'h0000, 40, -1, -1, "T1");
        check("T1/frames_nat", frames_nat, 1);
        check("T1/frames_br",  frames_br,  1);

        // T2: first out_valid two cycles after the final accept. The data has
        // the sign bit set to show bit-exact pass-through.
        feed(16'h8010, 1'b0);
        check("T2/lat_valid_1", bus_nat.out_valid, 0);
        @(negedge clk);
        check("T2/lat_valid_2", bus_nat.out_valid, 0);
        @(negedge clk);
        check("T2/lat_valid_3", bus_nat.out_valid, 1);
        expect_frame(16'h8010, 0, -1, -1, "T2");
        check("T2/frames_nat", frames_nat, 2);
        check("T2/overflow", overflow_nat, 0);

        // T3: backpressure. 20 samples with fft_ready low, and the last 4 are dropped.
        fft_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("T3/in_ready_%0d", i), bus_nat.in_ready, (i < 16));
            in_valid = 1'b1;
            in_data  = 16'h0300 + W'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("T3/overflow_nat", overflow_nat, 1);
        check("T3/overflow_br",  overflow_br,  1);
        check("T3/no_output",    bus_nat.out_valid, 0);
        fft_ready = 1'b1;
        expect_frame(16'h0300, 10, -1, -1, "T3a");
        expect_frame(16'h0308, 1,  -1, -1, "T3b");
        check("T3/frames_nat", frames_nat, 4);
        check("T3/in_ready",   bus_nat.in_ready, 1);

        // T4: fft_ready falls at beat 3 and the burst still completes. The
        // next frame waits.
        fft_ready = 1'b0;
        feed(16'h0400, 1'b0);
        feed(16'h0408, 1'b0);
        @(negedge clk);
        check("T4/in_ready_full", bus_nat.in_ready, 0);
        check("T4/overflow_sticky", overflow_nat, 1);
        fft_ready = 1'b1;
        expect_frame(16'h0400, 10, 3, -1, "T4a");
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus_nat.out_valid) seen++;
        end
        check("T4/held_off", seen, 0);
        check("T4/frames_mid", frames_nat, 5);
        fft_ready = 1'b1;
        expect_frame(16'h0408, 5, -1, -1, "T4b");
        check("T4/frames_nat", frames_nat, 6);

        // T5: random gaps on the input, and the output matches T1.
        feed(16'h0000, 1'b1);
        expect_frame(16'h0000, 40, -1, -1, "T5");
        check("T5/frames_nat", frames_nat, 7);

        // T6: reset at burst beat 4, followed by a fresh frame.
        feed(16'h0600, 1'b0);
        expect_frame(16'h0600, 40, -1, 4, "T6a");
        check_idle_state("T6/after_reset", 16'd0);
        reset = 1'b0;
        @(negedge clk);
        feed(16'h0700, 1'b0);
        expect_frame(16'h0700, 40, -1, -1, "T6b");
        check("T6/frames_nat", frames_nat, 1);
        check("T6/frames_br",  frames_br,  1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
